f_div_ctrl: RTL

//   Controller/sequencer for the frequency-divider datapath: three independent

---
 rtl/f_div_ctrl_if.sv | 29 ++
 rtl/f_div_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/f_div_ctrl_if.sv
// ============================================================================
// Module : f_div_ctrl_if
// Brief  : Valid/ready divisor-configuration port of the frequency divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface f_div_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_sel;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_sel, cfg_div,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_div,
        output cfg_ready, cfg_done, cfg_err
    );
endinterface

`default_nettype wire

// File: rtl/f_div_ctrl.sv
// ============================================================================
// Module : f_div_ctrl
// Brief  : Three divide-by-N channels with glitch-free runtime divisor update.
//          Optional macro DIV_CTRL_SYNC_EN adds a sync_req phase-align input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module f_div_ctrl #(
    parameter int CNT_W     = 4,
    parameter int DIV0_INIT = 2,
    parameter int DIV1_INIT = 3,
    parameter int DIV2_INIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_n,
`ifdef DIV_CTRL_SYNC_EN
    input  logic        sync_req,
`endif
    input  logic [2:0]  ch_en,
    f_div_ctrl_if.slave cfg,
    output logic [2:0]  div_out,
    output logic [2:0]  div_tick
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_en_q;
    logic [1:0]       r_sel_q;
    logic [CNT_W-1:0] r_div_q;
    logic             r_done;
    logic             r_err;

    logic             w_sync;
    logic [3:0]       w_en4;
    logic [3:0]       w_tick4;
    logic             w_hs;
    logic             w_bad;
    logic             w_idle_load;
    logic             w_pend_load;
    logic             w_load;
    logic [1:0]       w_load_sel;
    logic [CNT_W-1:0] w_load_div;

`ifdef DIV_CTRL_SYNC_EN
    assign w_sync = sync_req;
`else
    assign w_sync = 1'b0;
`endif

    // Padded to four entries so the illegal select value 3 indexes safely.
    assign w_en4   = {1'b0, r_en_q};
    assign w_tick4 = {1'b0, div_tick};

    assign w_hs        = cfg.cfg_valid && (r_state == ST_IDLE);
    assign w_bad       = (cfg.cfg_div < CNT_W'(2)) || (cfg.cfg_sel == 2'd3);
    assign w_idle_load = w_hs && !w_bad && !w_en4[cfg.cfg_sel];
    assign w_pend_load = (r_state == ST_PEND) &&
                         (!w_en4[r_sel_q] || w_tick4[r_sel_q] || w_sync);
    assign w_load      = w_idle_load || w_pend_load;
    assign w_load_sel  = (r_state == ST_PEND) ? r_sel_q : cfg.cfg_sel;
    assign w_load_div  = (r_state == ST_PEND) ? r_div_q : cfg.cfg_div;

    assign cfg.cfg_ready = (r_state == ST_IDLE);
    assign cfg.cfg_done  = r_done;
    assign cfg.cfg_err   = r_err;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_en_q  <= 3'b000;
            r_sel_q <= 2'd0;
            r_div_q <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_en_q <= ch_en;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else if (!w_en4[cfg.cfg_sel]) begin
                            r_done <= 1'b1;
                        end else begin
                            r_sel_q <= cfg.cfg_sel;
                            r_div_q <= cfg.cfg_div;
                            r_state <= ST_PEND;
                        end
                    end
                end
                ST_PEND: begin
                    if (w_pend_load) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_ch
            localparam logic [CNT_W-1:0] C_INIT =
                (i == 0) ? CNT_W'(DIV0_INIT) :
                (i == 1) ? CNT_W'(DIV1_INIT) : CNT_W'(DIV2_INIT);

            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_div;
            logic [CNT_W:0]   w_half;
            logic             w_sel_me;

            // One extra bit keeps (div+1) from wrapping at div = 2^CNT_W-1.
            assign w_half      = ({1'b0, r_div} + (CNT_W+1)'(1)) >> 1;
            assign w_sel_me    = (w_load_sel == 2'(i));
            assign div_out[i]  = r_en_q[i] && ({1'b0, r_cnt} < w_half);
            assign div_tick[i] = r_en_q[i] && (r_cnt == r_div - CNT_W'(1));

            always_ff @(posedge clk_in) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_div <= C_INIT;
                end else begin
                    if (w_load && w_sel_me) begin
                        r_div <= w_load_div;
                    end
                    if (!r_en_q[i]) begin
                        r_cnt <= '0;
                    end else if (w_pend_load && w_sel_me) begin
                        r_cnt <= '0;
                    end else if (w_sync || div_tick[i]) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire
